// File: rtl/demux_deserializer_pkg.sv
// Shared definitions for the deserializer and its matching serializer:
// FSM state encodings, default word width and the slot-ordering helper.
package demux_deserializer_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic {
    COLLECT = 1'b0,
    STALL   = 1'b1
  } state_e;

  // Maps a serial bit position to its parallel slot (and back; the mapping is its own inverse).
  function automatic int slot_order(input int pos, input int width, input bit msb_first);
    return msb_first ? (width - 1 - pos) : pos;
  endfunction

endpackage

// File: rtl/demux_deserializer_demux1to2.sv
// 1:2 demultiplexer; counterpart of the existing 2:1 mux used by the serializer.
module demux1to2 (
  input  logic d,
  input  logic sel,
  output logic y0,
  output logic y1
);

  assign y0 = d & ~sel;
  assign y1 = d & sel;

endmodule

// File: rtl/demux_deserializer.sv
// Serial-to-parallel deserializer with a one-word output slot and a
// COLLECT/STALL handshake FSM that back-pressures the serial input.
module demux_deserializer
  import demux_deserializer_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       din,
  input  logic                       din_valid,
  output logic                       din_ready,
  input  logic                       flush,
  output logic [WIDTH-1:0]           dout,
  output logic                       dout_valid,
  input  logic                       dout_ready,
  output logic [$clog2(WIDTH):0]     bit_count
);

  localparam int CW = $clog2(WIDTH) + 1;

  state_e            state_q, state_d;
  logic [CW-1:0]     count_q, count_d;
  logic [WIDTH-1:0]  collect_q, collect_d;
  logic [WIDTH-1:0]  dout_q, dout_d;
  logic              dv_q, dv_d;

  logic [WIDTH-1:0]  collect_wr;
  logic [WIDTH-1:0]  slot_we;
  logic [WIDTH-1:0]  unused_y0;
  logic              accept;
  logic              last_bit;
  logic              slot_free;

  assign accept    = din_valid && (state_q == COLLECT) && !flush;
  assign last_bit  = (count_q == CW'(WIDTH - 1));
  assign slot_free = !dv_q || dout_ready;

  // Each slot gets its own demux: only the slot addressed by bit_count sees the write strobe.
  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_slot
      localparam int POS = slot_order(gi, WIDTH, MSB_FIRST);
      logic hit;
      assign hit = (count_q == CW'(POS));
      demux1to2 u_demux (
        .d   (accept),
        .sel (hit),
        .y0  (unused_y0[gi]),
        .y1  (slot_we[gi])
      );
      assign collect_wr[gi] = slot_we[gi] ? din : collect_q[gi];
    end
  endgenerate

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    collect_d = collect_q;
    dout_d    = dout_q;
    dv_d      = dv_q;

    unique case (state_q)
      COLLECT: begin
        if (dv_q && dout_ready) begin
          dv_d = 1'b0;
        end
        if (flush) begin
          count_d   = '0;
          collect_d = '0;
        end else if (accept) begin
          collect_d = collect_wr;
          if (!last_bit) begin
            count_d = count_q + CW'(1);
          end else if (slot_free) begin
            dout_d  = collect_wr;
            dv_d    = 1'b1;
            count_d = '0;
          end else begin
            count_d = CW'(WIDTH);
            state_d = STALL;
          end
        end
      end
      STALL: begin
        // The parked word moves into the slot the same edge the consumer drains it.
        if (dv_q && dout_ready) begin
          dout_d  = collect_q;
          dv_d    = 1'b1;
          count_d = '0;
          state_d = COLLECT;
        end
      end
      default: state_d = COLLECT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= COLLECT;
      count_q   <= '0;
      collect_q <= '0;
      dout_q    <= '0;
      dv_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      collect_q <= collect_d;
      dout_q    <= dout_d;
      dv_q      <= dv_d;
    end
  end

  assign din_ready  = (state_q == COLLECT);
  assign dout       = dout_q;
  assign dout_valid = dv_q;
  assign bit_count  = count_q;

endmodule

// File: tb/tb_demux_deserializer.sv
// Scoreboarded bench for demux_deserializer: LSB-first instance checked by a
// handshake monitor, plus an MSB-first instance checked directly.
module tb_demux_deserializer;

  logic       clk = 1'b0;
  logic       rst;
  logic       din, din_valid, flush, dout_ready;
  logic       din_ready, dout_valid;
  logic [7:0] dout;
  logic [3:0] bit_count;

  logic       m_din, m_din_valid, m_dout_ready;
  logic       m_din_ready, m_dout_valid;
  logic [7:0] m_dout;
  logic [3:0] m_bit_count;

  int tests = 0;
  int fails = 0;
  logic [7:0] sb[$];

  always #5 clk = ~clk;

  demux_deserializer #(.WIDTH(8), .MSB_FIRST(1'b0)) u_dut (
    .clk        (clk),
    .rst        (rst),
    .din        (din),
    .din_valid  (din_valid),
    .din_ready  (din_ready),
    .flush      (flush),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .bit_count  (bit_count)
  );

  demux_deserializer #(.WIDTH(8), .MSB_FIRST(1'b1)) u_msb (
    .clk        (clk),
    .rst        (rst),
    .din        (m_din),
    .din_valid  (m_din_valid),
    .din_ready  (m_din_ready),
    .flush      (1'b0),
    .dout       (m_dout),
    .dout_valid (m_dout_valid),
    .dout_ready (m_dout_ready),
    .bit_count  (m_bit_count)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end else begin
      $display("[TB] ok   %s = 0x%0h", name, act);
    end
  endtask

  // Monitor: a word leaves the DUT on each valid/ready handshake.
  always @(negedge clk) begin
    if (!rst && dout_valid && dout_ready) begin
      tests++;
      if (sb.size() == 0) begin
        fails++;
        $display("[TB] FAIL unexpected_word: got 0x%0h, expected none", dout);
      end else begin
        logic [7:0] exp;
        exp = sb.pop_front();
        if (dout !== exp) begin
          fails++;
          $display("[TB] FAIL word: got 0x%0h, expected 0x%0h", dout, exp);
        end else begin
          $display("[TB] word 0x%0h", dout);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    din       = b;
    din_valid = 1'b1;
    tick();
    din_valid = 1'b0;
  endtask

  task automatic send_word(input logic [7:0] w, input bit expect_out);
    if (expect_out) sb.push_back(w);
    for (int i = 0; i < 8; i++) send_bit(w[i]);
  endtask

  initial begin
    logic [7:0] gap_word;
    logic [7:0] msb_seq;
    rst = 1'b1; din = 1'b0; din_valid = 1'b0; flush = 1'b0; dout_ready = 1'b1;
    m_din = 1'b0; m_din_valid = 1'b0; m_dout_ready = 1'b1;
    tick(); tick();
    rst = 1'b0;
    check("reset_dout_valid", 32'(dout_valid), 32'd0);
    check("reset_dout", 32'(dout), 32'h00);
    check("reset_bit_count", 32'(bit_count), 32'd0);
    check("reset_din_ready", 32'(din_ready), 32'd1);

    // Basic word with ready consumer
    send_word(8'hA5, 1'b1);
    check("a5_dout_valid", 32'(dout_valid), 32'd1);
    check("a5_dout", 32'(dout), 32'hA5);
    check("a5_bit_count", 32'(bit_count), 32'd0);
    tick();
    check("a5_valid_drop", 32'(dout_valid), 32'd0);

    // Back-pressure: second word parks in STALL
    dout_ready = 1'b0;
    send_word(8'h3C, 1'b1);
    send_word(8'h81, 1'b1);
    check("stall_din_ready", 32'(din_ready), 32'd0);
    check("stall_dout_held", 32'(dout), 32'h3C);
    check("stall_bit_count", 32'(bit_count), 32'd8);
    din = 1'b1; din_valid = 1'b1; flush = 1'b1;
    tick(); tick();
    din_valid = 1'b0; flush = 1'b0;
    check("stall_ignores_din_flush", 32'(bit_count), 32'd8);
    check("stall_dout_still", 32'(dout), 32'h3C);
    dout_ready = 1'b1;
    tick();
    dout_ready = 1'b0;
    check("unstall_dout", 32'(dout), 32'h81);
    check("unstall_dout_valid", 32'(dout_valid), 32'd1);
    check("unstall_din_ready", 32'(din_ready), 32'd1);
    check("unstall_bit_count", 32'(bit_count), 32'd0);
    dout_ready = 1'b1;
    tick();
    check("unstall_drain", 32'(dout_valid), 32'd0);

    // Valid every third cycle; din toggles while invalid
    gap_word = 8'h5A;
    sb.push_back(gap_word);
    for (int i = 0; i < 8; i++) begin
      send_bit(gap_word[i]);
      if (i < 7) check($sformatf("gap_count_%0d", i), 32'(bit_count), 32'(i + 1));
      din = ~gap_word[i]; tick();
      din = gap_word[i];  tick();
      if (i < 7) check($sformatf("gap_hold_%0d", i), 32'(bit_count), 32'(i + 1));
    end
    check("gap_dout", 32'(dout), 32'h5A);

    // Flush after three bits
    send_bit(1'b1); send_bit(1'b1); send_bit(1'b0);
    check("pre_flush_count", 32'(bit_count), 32'd3);
    din = 1'b1; din_valid = 1'b1; flush = 1'b1;
    tick();
    din_valid = 1'b0; flush = 1'b0;
    check("flush_count", 32'(bit_count), 32'd0);
    send_word(8'hFF, 1'b1);
    check("flush_then_ff", 32'(dout), 32'hFF);
    tick();

    // Reset mid-word
    for (int i = 0; i < 5; i++) send_bit(1'b1);
    check("mid_count", 32'(bit_count), 32'd5);
    rst = 1'b1; tick(); rst = 1'b0;
    check("rst_mid_count", 32'(bit_count), 32'd0);
    check("rst_mid_dout", 32'(dout), 32'h00);
    check("rst_mid_valid", 32'(dout_valid), 32'd0);
    send_word(8'h0F, 1'b1);
    check("rst_mid_0f", 32'(dout), 32'h0F);
    tick();

    // Reset while in STALL discards both pending words
    dout_ready = 1'b0;
    send_word(8'h11, 1'b0);
    send_word(8'h22, 1'b0);
    check("pre_rst_stall", 32'(din_ready), 32'd0);
    rst = 1'b1; tick(); rst = 1'b0;
    check("rst_stall_din_ready", 32'(din_ready), 32'd1);
    check("rst_stall_valid", 32'(dout_valid), 32'd0);
    check("rst_stall_dout", 32'(dout), 32'h00);
    check("rst_stall_count", 32'(bit_count), 32'd0);
    tick();
    check("rst_stall_no_word", 32'(dout_valid), 32'd0);
    dout_ready = 1'b1;
    send_word(8'h0F, 1'b1);
    check("rst_stall_0f", 32'(dout), 32'h0F);
    tick();

    // MSB-first instance: 0,0,0,1,0,0,1,0 in arrival order
    msb_seq = 8'b0100_1000;
    for (int i = 0; i < 8; i++) begin
      m_din = msb_seq[i]; m_din_valid = 1'b1;
      tick();
    end
    m_din_valid = 1'b0;
    check("msb_dout_valid", 32'(m_dout_valid), 32'd1);
    check("msb_dout", 32'(m_dout), 32'h12);

    // Bounded drain of the scoreboard
    for (int i = 0; i < 20 && sb.size() != 0; i++) tick();
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("[TB] FAIL drain: got %0d words pending, expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/demux_deserializer.md
DEMUX_DESERIALIZER -- requirements
Module: demux_deserializer

Interface
REQ-001 Parameter WIDTH, default 8: number of bits per assembled word; the block SHALL support any WIDTH from 2 to 32.
REQ-002 Parameter MSB_FIRST, default 0: when 0, the first serial bit received SHALL land in dout[0]; when 1, it SHALL land in dout[WIDTH-1].
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 din  input  1  serial data bit.
REQ-006 din_valid  input  1  din holds a valid bit this cycle.
REQ-007 din_ready  output  1  block can accept a bit this cycle.
REQ-008 flush  input  1  discard the partially assembled word.
REQ-009 dout  output  WIDTH  assembled parallel word.
REQ-010 dout_valid  output  1  dout holds a complete word.
REQ-011 dout_ready  input  1  consumer accepts dout this cycle.
REQ-012 bit_count  output  clog2(WIDTH)+1  number of bits collected in the current partial word.

Function
REQ-013 A bit SHALL be accepted on any rising edge where din_valid=1 and din_ready=1; a 1-bit select derived from bit_count SHALL route the bit to its slot in the collect register, and no other collect bit SHALL change.
REQ-014 The FSM SHALL have two states: COLLECT and STALL; din_ready SHALL be 1 in COLLECT and 0 in STALL (combinational, state only).
REQ-015 In COLLECT, accepting a bit with bit_count < WIDTH-1 SHALL increment bit_count by 1.
REQ-016 In COLLECT, accepting the final bit (bit_count = WIDTH-1) with the output slot free (dout_valid=0, or dout_ready=1) SHALL load dout with the completed word including that bit, set dout_valid=1 on the same edge, and set bit_count to 0; latency from final bit to dout_valid is 1 cycle.
REQ-017 In COLLECT, accepting the final bit while the output slot is occupied and dout_ready=0 SHALL store the completed word in the collect register, set bit_count to WIDTH, and move to STALL.
REQ-018 In STALL, when dout_valid=1 and dout_ready=1, dout SHALL load the collect word, dout_valid SHALL stay 1, bit_count SHALL become 0, and the FSM SHALL return to COLLECT on the same edge.
REQ-019 In states other than those of REQ-016 and REQ-018, a cycle with dout_valid=1 and dout_ready=1 SHALL clear dout_valid; dout SHALL hold its value when dout_valid=0.
REQ-020 dout and dout_valid SHALL remain stable while dout_valid=1 and dout_ready=0.
REQ-021 flush=1 in COLLECT SHALL clear bit_count and the collect register, and SHALL ignore any simultaneous din bit; flush SHALL have no effect in STALL or on the output slot.
REQ-022 bit_count SHALL never exceed WIDTH; wrap to 0 occurs only per REQ-016, REQ-018 or REQ-021.
REQ-023 din SHALL be ignored whenever din_valid=0 or din_ready=0.

Reset
REQ-024 rst=1 SHALL, at the next rising edge, set state=COLLECT, bit_count=0, collect register=0, dout=0 and dout_valid=0, taking priority over flush, din and dout_ready.
REQ-025 Reset asserted mid-word or in STALL SHALL discard every partial and pending word; no word SHALL be output afterwards without a fresh WIDTH bits.

Structure
REQ-026 The state encodings (COLLECT=0, STALL=1) and the default WIDTH SHALL reside in a shared package or include file for reuse by the matching serializer.
REQ-027 The per-bit routing SHALL be a sub-module demux1to2 (inputs d and sel; outputs y0 and y1), instantiated as a tree or per slot, as the counterpart of the existing 2:1 mux.

Verification
REQ-028 WIDTH=8, dout_ready=1: bits 1,0,1,0,0,1,0,1 on consecutive cycles -> dout=0xA5, dout_valid=1 one cycle after the 8th bit, then 0 the following cycle.
REQ-029 dout_ready=0: send 0x3C then 0x81 -> dout=0x3C held, din_ready=0 after the 16th bit; raise dout_ready for 1 cycle -> dout=0x81 on the next edge, din_ready=1.
REQ-030 Random din_valid gaps (for example, valid every 3rd cycle) while sending 0x5A -> dout=0x5A, with bit_count advancing only on valid cycles.
REQ-031 Three bits then flush=1 with din_valid=1 -> bit_count=0; then send 0xFF -> dout=0xFF.
REQ-032 rst for 1 cycle after 5 bits, and separately while in STALL -> all outputs 0 and state COLLECT; the next 8 bits 0x0F -> dout=0x0F.
REQ-033 MSB_FIRST=1: bits 0,0,0,1,0,0,1,0 -> dout=0x12.
